// File: rtl/ensemble_stream_arbiter_if.sv
// AXI-Stream bundle shared by the three classifier result streams and the merged output.
// tid is only meaningful on the merged side; sources leave it out of their modport.
interface ensemble_stream_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [1:0]            tid;

    modport master (output tdata, tkeep, tvalid, tlast, tid, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ensemble_stream_arbiter.sv
// Packet round-robin merge of three AXI-Stream sources; one idle arbitration cycle per packet, then zero-latency beats.
// Backpressure: m_axis.tready is passed straight through to the granted source only; others see tready=0.
module ensemble_stream_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arb_enable,
    ensemble_stream_arbiter_if.slave     s_axis_0,
    ensemble_stream_arbiter_if.slave     s_axis_1,
    ensemble_stream_arbiter_if.slave     s_axis_2,
    ensemble_stream_arbiter_if.master    m_axis,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         pkt_count_0,
    output logic [CNT_WIDTH-1:0]         pkt_count_1,
    output logic [CNT_WIDTH-1:0]         pkt_count_2
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_grant;
    logic [1:0]            w_grant_nxt;
    logic [1:0]            r_last_grant;
    logic [1:0]            w_last_grant_nxt;
    logic [CNT_WIDTH-1:0]  r_pkt_count [3];
    logic [2:0]            w_cnt_inc;

    logic [2:0]            w_req;
    logic [1:0]            w_cand1;
    logic [1:0]            w_cand2;
    logic [1:0]            w_pick;

    logic                  w_sel_vld;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_dat;
    logic [KEEP_WIDTH-1:0] w_sel_keep;
    logic                  w_m_vld;
    logic [2:0]            w_rdy;

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign w_req = {s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};

    // Search order after the previous winner: last+1, last+2, then last itself.
    always_comb begin
        w_cand1 = f_next(r_last_grant);
        w_cand2 = f_next(w_cand1);
        w_pick  = r_last_grant;
        if (w_req[w_cand1]) begin
            w_pick = w_cand1;
        end else if (w_req[w_cand2]) begin
            w_pick = w_cand2;
        end
    end

    always_comb begin
        w_sel_vld  = s_axis_0.tvalid;
        w_sel_last = s_axis_0.tlast;
        w_sel_dat  = s_axis_0.tdata;
        w_sel_keep = s_axis_0.tkeep;
        case (r_grant)
            2'd1: begin
                w_sel_vld  = s_axis_1.tvalid;
                w_sel_last = s_axis_1.tlast;
                w_sel_dat  = s_axis_1.tdata;
                w_sel_keep = s_axis_1.tkeep;
            end
            2'd2: begin
                w_sel_vld  = s_axis_2.tvalid;
                w_sel_last = s_axis_2.tlast;
                w_sel_dat  = s_axis_2.tdata;
                w_sel_keep = s_axis_2.tkeep;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_cnt_inc        = '0;
        w_m_vld          = 1'b0;
        w_rdy            = '0;
        case (r_state)
            IDLE: begin
                if (arb_enable && (|w_req)) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_m_vld        = w_sel_vld;
                w_rdy[r_grant] = m_axis.tready;
                if (w_sel_vld && m_axis.tready && w_sel_last) begin
                    w_last_grant_nxt     = r_grant;
                    w_cnt_inc[r_grant]   = 1'b1;
                    w_state_nxt          = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd2;
            for (int i = 0; i < 3; i++) begin
                r_pkt_count[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            for (int i = 0; i < 3; i++) begin
                if (w_cnt_inc[i]) begin
                    r_pkt_count[i] <= r_pkt_count[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign m_axis.tvalid   = w_m_vld;
    assign m_axis.tdata    = w_sel_dat;
    assign m_axis.tkeep    = w_sel_keep;
    assign m_axis.tlast    = w_sel_last;
    assign m_axis.tid      = r_grant;

    assign s_axis_0.tready = w_rdy[0];
    assign s_axis_1.tready = w_rdy[1];
    assign s_axis_2.tready = w_rdy[2];

    assign busy        = (r_state == BUSY);
    assign pkt_count_0 = r_pkt_count[0];
    assign pkt_count_1 = r_pkt_count[1];
    assign pkt_count_2 = r_pkt_count[2];

endmodule
